// File: rtl/comb_dly.sv
// comb_dly: d-deep, n-wide shift register holding the previously kept samples.
// The oldest entry (d takes ago) is presented on dout.
module comb_dly #(
  parameter int unsigned n = 9,
  parameter int unsigned d = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         shift,
  input  logic [n-1:0] din,
  output logic [n-1:0] dout
);

  logic [n-1:0] dly [d];

  // Delay line: clears asynchronously, shifts one place on each kept sample
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < int'(d); k++) dly[k] <= '0;
    end else if (shift) begin
      dly[0] <= din;
      for (int k = 1; k < int'(d); k++) dly[k] <= dly[k-1];
    end
  end

  assign dout = dly[d-1];

endmodule

// File: rtl/comb_decimator.sv
// comb_decimator: CIC comb and rate-reduction stage fed by an integrator.
// Keeps every r-th enabled sample and outputs its difference to the sample
// kept d decimation periods earlier, scaled down to m bits.
// Build option: COMB_DECIMATOR_ROUND_EN selects round-half-up instead of
// floor when m < n.
module comb_decimator #(
  parameter int unsigned n = 9,
  parameter int unsigned m = 9,
  parameter int unsigned r = 4,
  parameter int unsigned d = 1
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic                sync,
  input  logic signed [n-1:0] in,
  output logic signed [m-1:0] out,
  output logic                out_stb
);

  localparam int unsigned sh   = n - m;
  localparam int unsigned cw   = (r > 1) ? $clog2(r) : 1;
  localparam logic [cw-1:0] last_cnt = cw'(r - 1);
`ifdef COMB_DECIMATOR_ROUND_EN
  localparam int unsigned shm1 = (sh > 0) ? sh - 1 : 0;
  localparam logic signed [n-1:0] half = (sh > 0) ? (n'(1) << shm1) : '0;
`endif

  logic [cw-1:0]       cnt;
  logic [cw-1:0]       cnt_nxt;
  logic                take_c;
  logic signed [n-1:0] tail;
  logic signed [n-1:0] diff_c;
  logic signed [n-1:0] adj_c;
  logic signed [m-1:0] out_nxt;

  comb_dly #(
    .n (n),
    .d (d)
  ) u_dly (
    .clk   (clk),
    .clr_n (clr_n),
    .shift (take_c),
    .din   (in),
    .dout  (tail)
  );

  // Take decision, phase advance, wrapping difference and output scaling
  always_comb begin
    take_c  = en && (sync || (cnt == last_cnt));
    cnt_nxt = cnt;
    if (take_c || sync) cnt_nxt = '0;
    else if (en)        cnt_nxt = cnt + cw'(1);
    diff_c  = in - tail;
`ifdef COMB_DECIMATOR_ROUND_EN
    adj_c   = diff_c + half;
`else
    adj_c   = diff_c;
`endif
    out_nxt = take_c ? m'(adj_c >>> sh) : out;
  end

  // Phase counter and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt     <= '0;
      out     <= '0;
      out_stb <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      out     <= out_nxt;
      out_stb <= take_c;
    end
  end

endmodule

// File: tb/tb_comb_decimator.sv
// tb_comb_decimator: randomized scoreboard bench for comb_decimator.
// Two instances share stimulus: full width (m = 9) and reduced width (m = 7).
module tb_comb_decimator;

  localparam int N  = 9;
  localparam int R  = 4;
  localparam int D  = 1;

  logic                clk = 1'b0;
  logic                clr_n = 1'b0;
  logic                en = 1'b0;
  logic                sync = 1'b0;
  logic signed [N-1:0] in = '0;
  logic signed [8:0]   out9;
  logic signed [6:0]   out7;
  logic                stb9, stb7;

  comb_decimator #(.n(N), .m(9), .r(R), .d(D)) u_dut9 (
    .clk(clk), .clr_n(clr_n), .en(en), .sync(sync), .in(in),
    .out(out9), .out_stb(stb9)
  );

  comb_decimator #(.n(N), .m(7), .r(R), .d(D)) u_dut7 (
    .clk(clk), .clr_n(clr_n), .en(en), .sync(sync), .in(in),
    .out(out7), .out_stb(stb7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state
  int           ph;
  logic [N-1:0] hist[$];
  logic [N-1:0] acc;
  int           q9[$];
  int           q7[$];
  int           last9, last7;
  logic         pend;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0;
    hist.delete();
    for (int k = 0; k < D; k++) hist.push_back('0);
    acc = '0;
    q9.delete();
    q7.delete();
    last9 = 0;
    last7 = 0;
    pend  = 1'b0;
  endtask

  // one input cycle: drive after negedge, predict what the next posedge does
  task automatic step(input logic e, input logic s, input int x);
    logic signed [N-1:0] v, df, ad;
    logic signed [6:0]   e7;
    @(negedge clk);
    #1;
    if (e) begin
      v   = acc;
      acc = acc + N'(x);
    end else begin
      v = N'($urandom);
    end
    en   = e;
    sync = s;
    in   = v;
    pend = 1'b0;
    if (e && (s || ph == R - 1)) begin
      ph = 0;
      df = v - hist[D-1];
`ifdef COMB_DECIMATOR_ROUND_EN
      ad = df + 9'sd2;
`else
      ad = df;
`endif
      e7 = 7'(ad >>> 2);
      q9.push_back(int'(df));
      q7.push_back(int'(e7));
      hist.push_front(v);
      void'(hist.pop_back());
      pend = 1'b1;
    end else if (s) begin
      ph = 0;
    end else if (e) begin
      ph = ph + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    en    = 1'b0;
    sync  = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("reset_out9", int'(out9), 0);
    chk("reset_out7", int'(out7), 0);
    chk("reset_stb9", int'(stb9), 0);
    chk("reset_stb7", int'(stb7), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  // monitor: compare strobes every cycle, pop expectations on strobe, check out holds
  always @(negedge clk) begin
    if (clr_n) begin
      chk("stb9", int'(stb9), int'(pend));
      chk("stb7", int'(stb7), int'(pend));
      if (stb9) begin
        if (q9.size() == 0) chk("stb9_unexpected", 1, 0);
        else last9 = q9.pop_front();
      end
      if (stb7) begin
        if (q7.size() == 0) chk("stb7_unexpected", 1, 0);
        else last7 = q7.pop_front();
      end
      chk("out9", int'(out9), last9);
      chk("out7", int'(out7), last7);
    end
  end

  initial begin
    model_reset();
    #12;
    chk("init_out9", int'(out9), 0);
    chk("init_stb9", int'(stb9), 0);
    @(negedge clk);
    #1;
    clr_n = 1'b1;

    // ramp step 7: out 21 then 28
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 7);

    // ramp step 60 wrapping: out 240 steady
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 60);

    // small negative steps: diff -6 exercises floor/round on m = 7
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, (i % 2 == 0) ? -1 : -2);

    // sync with en at cnt = 1, then sync with en = 0
    step(1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 5);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5);
    step(1'b1, 1'b0, 5);
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3);

    // en toggling: out holds between takes
    for (int i = 0; i < 16; i++) step(1'(i % 2 == 0), 1'b0, 9);

    // reset mid-period (cnt = 2, out = 28), then zero-history restart
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 7);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 7);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 255)) - 128);
    end
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    @(negedge clk);
    chk("q9_drained", q9.size(), 0);
    chk("q7_drained", q7.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
